// File: rtl/multiplexer_4_inputs_rr.sv
// Four valid/ready sources merged onto one registered valid/ready sink.
// A round-robin pointer picks the next source; S tags each word with the index of the source that produced it.
module multiplexer_4_inputs_rr #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] X0,
  input  logic [W-1:0] X1,
  input  logic [W-1:0] X2,
  input  logic [W-1:0] X3,
  input  logic         V0,
  input  logic         V1,
  input  logic         V2,
  input  logic         V3,
  output logic         R0,
  output logic         R1,
  output logic         R2,
  output logic         R3,
  output logic [W-1:0] Z,
  output logic         ZV,
  input  logic         ZR,
  output logic [1:0]   S
);

  logic [W-1:0] z_q, z_d;
  logic         zv_q, zv_d;
  logic [1:0]   s_q, s_d;
  logic [1:0]   p_q, p_d;

  logic [3:0]   vVec;
  logic [1:0]   scanIdx;
  logic [1:0]   grant;
  logic         grantValid;
  logic         loadEn;
  logic         accept;
  logic [W-1:0] xSel;

  assign vVec = {V3, V2, V1, V0};

  // The first valid source at or after the pointer wins.
  always_comb begin
    grant      = 2'b00;
    grantValid = 1'b0;
    scanIdx    = 2'b00;
    for (int k = 0; k < 4; k++) begin
      scanIdx = p_q + 2'(k);
      if (!grantValid && vVec[scanIdx]) begin
        grant      = scanIdx;
        grantValid = 1'b1;
      end
    end
  end

  always_comb begin
    xSel = X0;
    case (grant)
      2'd0:    xSel = X0;
      2'd1:    xSel = X1;
      2'd2:    xSel = X2;
      default: xSel = X3;
    endcase
  end

  // The output register can take a word when it is empty or being drained.
  assign loadEn = !zv_q || ZR;
  assign accept = loadEn && grantValid && !reset;

  assign R0 = accept && (grant == 2'd0);
  assign R1 = accept && (grant == 2'd1);
  assign R2 = accept && (grant == 2'd2);
  assign R3 = accept && (grant == 2'd3);

  always_comb begin
    z_d  = z_q;
    zv_d = zv_q;
    s_d  = s_q;
    p_d  = p_q;
    if (loadEn) begin
      if (grantValid) begin
        z_d  = xSel;
        s_d  = grant;
        zv_d = 1'b1;
        p_d  = grant + 2'd1;
      end else begin
        zv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z_q  <= '0;
      zv_q <= 1'b0;
      s_q  <= 2'b00;
      p_q  <= 2'b00;
    end else begin
      z_q  <= z_d;
      zv_q <= zv_d;
      s_q  <= s_d;
      p_q  <= p_d;
    end
  end

  assign Z  = z_q;
  assign ZV = zv_q;
  assign S  = s_q;

endmodule

// File: tb/tb_multiplexer_4_inputs_rr.sv
// Directed bench for the round-robin 4-to-1 merge; expected values are hand-computed.
module tb_multiplexer_4_inputs_rr;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] X0, X1, X2, X3;
  logic         V0, V1, V2, V3;
  logic         R0, R1, R2, R3;
  logic [W-1:0] Z;
  logic         ZV;
  logic         ZR;
  logic [1:0]   S;

  int assertionCount = 0;
  int failCount      = 0;

  multiplexer_4_inputs_rr #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .X0(X0), .X1(X1), .X2(X2), .X3(X3),
    .V0(V0), .V1(V1), .V2(V2), .V3(V3),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3),
    .Z(Z), .ZV(ZV), .ZR(ZR), .S(S)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertionCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic zr);
    {V3, V2, V1, V0} = v;
    ZR = zr;
    #1;
  endtask

  task automatic checkWord(input string tag, input logic [63:0] z, input logic [1:0] s, input logic zv);
    checkOutput({tag, ".Z"}, Z, z);
    checkOutput({tag, ".S"}, 64'(S), 64'(s));
    checkOutput({tag, ".ZV"}, 64'(ZV), 64'(zv));
  endtask

  function automatic logic [63:0] rVec();
    return 64'({R3, R2, R1, R0});
  endfunction

  logic [63:0] rrZ [8];
  logic [1:0]  rrS [8];

  initial begin
    rrZ = '{64'd1, 64'd2, 64'd4, 64'd8, 64'd1, 64'd2, 64'd4, 64'd8};
    rrS = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    reset = 1'b1;
    X0 = 64'd1; X1 = 64'd2; X2 = 64'd4; X3 = 64'd8;
    applyStimulus(4'b1111, 1'b1);

    // Reset held for two edges with every source requesting.
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("reset.R", rVec(), 64'h0);
      checkWord("reset", 64'h0, 2'd0, 1'b0);
    end

    // Release: channel 0 first, then strict rotation.
    reset = 1'b0;
    #1;
    checkOutput("release.R", rVec(), 64'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkWord($sformatf("rr%0d", i), rrZ[i], rrS[i], 1'b1);
    end

    // Pointer is 0 again; V2,V3 requesting -> 2 wins, then stall holding Z=4.
    applyStimulus(4'b1100, 1'b1);
    checkOutput("bp.grant2", rVec(), 64'b0100);
    tick();
    checkWord("bp.load", 64'd4, 2'd2, 1'b1);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("bp.stallR", rVec(), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("bp.stall%0d.R", i), rVec(), 64'h0);
      checkWord($sformatf("bp.stall%0d", i), 64'd4, 2'd2, 1'b1);
    end
    applyStimulus(4'b1000, 1'b1);
    checkOutput("bp.resumeR", rVec(), 64'b1000);
    tick();
    checkWord("bp.drain", 64'd8, 2'd3, 1'b1);

    // Pointer at 0 after serving 3; only 1 and 3 request: 1,3,1.
    applyStimulus(4'b1010, 1'b1);
    checkOutput("skip.g1.R", rVec(), 64'b0010);
    tick();
    checkWord("skip.g1", 64'd2, 2'd1, 1'b1);
    checkOutput("skip.g3.R", rVec(), 64'b1000);
    tick();
    checkWord("skip.g3", 64'd8, 2'd3, 1'b1);
    checkOutput("skip.g1b.R", rVec(), 64'b0010);
    tick();
    checkWord("skip.g1b", 64'd2, 2'd1, 1'b1);

    // Single source on channel 2, then source goes idle.
    X2 = 64'h0000_0000_DEAD_BEEF;
    applyStimulus(4'b0100, 1'b1);
    checkOutput("single.R", rVec(), 64'b0100);
    tick();
    checkWord("single.load", 64'hDEADBEEF, 2'd2, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single.idleR", rVec(), 64'h0);
    tick();
    checkWord("single.idle", 64'hDEADBEEF, 2'd2, 1'b0);

    // Pointer at 3; only V0 -> 0 granted, then stall and reset mid-stall.
    applyStimulus(4'b0001, 1'b1);
    checkOutput("rst.pre.R", rVec(), 64'b0001);
    tick();
    checkWord("rst.pre", 64'd1, 2'd0, 1'b1);
    applyStimulus(4'b1001, 1'b0);
    checkOutput("rst.stallR", rVec(), 64'h0);
    reset = 1'b1;
    #1;
    checkOutput("rst.activeR", rVec(), 64'h0);
    tick();
    checkWord("rst.flush", 64'h0, 2'd0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("rst.after.R", rVec(), 64'b0001);
    tick();
    checkWord("rst.after", 64'd1, 2'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
    $finish;
  end

endmodule
